alu_issue_stage: RTL and testbench

//  Execute-stage driver and collector for the pipeline ALU. Holds the ID/EX register and applies

---
 rtl/alu_issue_stage_pkg.sv | 43 ++++
 rtl/alu_issue_stage_fwd_mux3.sv | 32 +++
 rtl/alu_issue_stage.sv | 218 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU op encodings, forwarding-select codes and the ID/EX control bundle.
// Latency: none; constants and types only.
// Backpressure: none; constants and types only.
package alu_defs;

    // ALU operation encoding, shared with the alu block.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b111;

    // Forwarding selects driven by the hazard unit. 2'b11 is unused and
    // treated the same as FWD_REG.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Control bits carried through the ID/EX register.
    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic [2:0] alu_ctrl;
    } ctrl_e_t;

    // All-zero control word. This is a NOP in the pipeline: no register
    // write, no memory write, no branch, ALU op = ADD.
    localparam ctrl_e_t CTRL_BUBBLE = '{
        alu_src:    1'b0,
        reg_dst:    1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        alu_ctrl:   ALU_ADD
    };

endpackage

// File: rtl/alu_issue_stage_fwd_mux3.sv
// Forwarding selector: chooses the register-file value, the writeback result or the EX/MEM ALU output.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows sel and the three data inputs.
//
// Ports:
//   sel    forwarding code (FWD_REG / FWD_WB / FWD_MEM; 2'b11 acts as FWD_REG)
//   d_reg  operand read from the register file in decode
//   d_wb   result being written back
//   d_mem  ALU output held in the EX/MEM register
//   y      selected operand
module fwd_mux3
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d_reg,
    input  logic [WIDTH-1:0] d_wb,
    input  logic [WIDTH-1:0] d_mem,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d_reg;
        case (sel)
            FWD_WB:  y = d_wb;
            FWD_MEM: y = d_mem;
            default: y = d_reg;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute stage: holds the ID/EX register, forwards operands into the alu and captures its result in EX/MEM.
// Latency: decode inputs reach SrcA/SrcB one cycle later; the ALU result reaches ALUOutM two cycles after decode.
// Backpressure: StallE holds ID/EX and FlushE inserts a bubble (FlushE wins); EX/MEM loads every cycle.
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   StallE, FlushE               hazard-unit control of the ID/EX register
//   RD1D, RD2D, ImmExtD          decode operands and the sign-extended immediate
//   RsD, RtD, RdD                decode register indices
//   ALUControlD, *D control bits decode control word
//   ForwardAE, ForwardBE         operand forwarding selects
//   ResultW                      writeback result (forwarding source)
//   SrcA, SrcB, ALUControl       drive the alu
//   ALUResult, Zero              returned by the alu
//   RsE, RtE, WriteRegE,
//   RegWriteE, MemtoRegE         execute-stage state seen by the hazard unit
//   ALUOutM, WriteDataM, WriteRegM,
//   RegWriteM, MemtoRegM, MemWriteM, PCSrcM   EX/MEM register outputs
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [REGW-1:0]  RsD,
    input  logic [REGW-1:0]  RtD,
    input  logic [REGW-1:0]  RdD,
    input  logic [2:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic             RegDstD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             BranchD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    output logic [REGW-1:0]  RsE,
    output logic [REGW-1:0]  RtE,
    output logic [REGW-1:0]  WriteRegE,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [REGW-1:0]  WriteRegM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic             PCSrcM
);

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    ctrl_e_t          ctrl_e_q, ctrl_e_d;
    logic [WIDTH-1:0] rd1_e_q, rd1_e_d;
    logic [WIDTH-1:0] rd2_e_q, rd2_e_d;
    logic [WIDTH-1:0] imm_e_q, imm_e_d;
    logic [REGW-1:0]  rs_e_q, rs_e_d;
    logic [REGW-1:0]  rt_e_q, rt_e_d;
    logic [REGW-1:0]  rd_e_q, rd_e_d;

    always_comb begin
        ctrl_e_d = ctrl_e_q;
        rd1_e_d  = rd1_e_q;
        rd2_e_d  = rd2_e_q;
        imm_e_d  = imm_e_q;
        rs_e_d   = rs_e_q;
        rt_e_d   = rt_e_q;
        rd_e_d   = rd_e_q;
        if (FlushE) begin
            // Bubble clears data as well as control, so a flushed slot
            // presents zero operands to the alu.
            ctrl_e_d = CTRL_BUBBLE;
            rd1_e_d  = '0;
            rd2_e_d  = '0;
            imm_e_d  = '0;
            rs_e_d   = '0;
            rt_e_d   = '0;
            rd_e_d   = '0;
        end else if (!StallE) begin
            ctrl_e_d.alu_src    = ALUSrcD;
            ctrl_e_d.reg_dst    = RegDstD;
            ctrl_e_d.reg_write  = RegWriteD;
            ctrl_e_d.mem_to_reg = MemtoRegD;
            ctrl_e_d.mem_write  = MemWriteD;
            ctrl_e_d.branch     = BranchD;
            ctrl_e_d.alu_ctrl   = ALUControlD;
            rd1_e_d             = RD1D;
            rd2_e_d             = RD2D;
            imm_e_d             = ImmExtD;
            rs_e_d              = RsD;
            rt_e_d              = RtD;
            rd_e_d              = RdD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q <= CTRL_BUBBLE;
            rd1_e_q  <= '0;
            rd2_e_q  <= '0;
            imm_e_q  <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            rd_e_q   <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            rd1_e_q  <= rd1_e_d;
            rd2_e_q  <= rd2_e_d;
            imm_e_q  <= imm_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            rd_e_q   <= rd_e_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] alu_out_m_q, alu_out_m_d;

    fwd_mux3 #(.WIDTH(WIDTH)) u_fwd_a (
        .sel   (ForwardAE),
        .d_reg (rd1_e_q),
        .d_wb  (ResultW),
        .d_mem (alu_out_m_q),
        .y     (fwd_a)
    );

    fwd_mux3 #(.WIDTH(WIDTH)) u_fwd_b (
        .sel   (ForwardBE),
        .d_reg (rd2_e_q),
        .d_wb  (ResultW),
        .d_mem (alu_out_m_q),
        .y     (fwd_b)
    );

    // Store data must see the forwarded register value even when the alu
    // consumes the immediate, so WriteDataM is fed from fwd_b, not SrcB.
    assign SrcA       = fwd_a;
    assign SrcB       = ctrl_e_q.alu_src ? imm_e_q : fwd_b;
    assign ALUControl = ctrl_e_q.alu_ctrl;

    assign RsE       = rs_e_q;
    assign RtE       = rt_e_q;
    assign WriteRegE = ctrl_e_q.reg_dst ? rd_e_q : rt_e_q;
    assign RegWriteE = ctrl_e_q.reg_write;
    assign MemtoRegE = ctrl_e_q.mem_to_reg;

    // ------------------------------------------------------------------
    // EX/MEM register: no stall or flush of its own; a bubble in E
    // arrives here as a NOP.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] write_data_m_q, write_data_m_d;
    logic [REGW-1:0]  write_reg_m_q, write_reg_m_d;
    logic             reg_write_m_q, reg_write_m_d;
    logic             mem_to_reg_m_q, mem_to_reg_m_d;
    logic             mem_write_m_q, mem_write_m_d;
    logic             zero_m_q, zero_m_d;
    logic             branch_m_q, branch_m_d;

    always_comb begin
        alu_out_m_d    = ALUResult;
        write_data_m_d = fwd_b;
        write_reg_m_d  = WriteRegE;
        reg_write_m_d  = ctrl_e_q.reg_write;
        mem_to_reg_m_d = ctrl_e_q.mem_to_reg;
        mem_write_m_d  = ctrl_e_q.mem_write;
        zero_m_d       = Zero;
        branch_m_d     = ctrl_e_q.branch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_m_q    <= '0;
            write_data_m_q <= '0;
            write_reg_m_q  <= '0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            zero_m_q       <= 1'b0;
            branch_m_q     <= 1'b0;
        end else begin
            alu_out_m_q    <= alu_out_m_d;
            write_data_m_q <= write_data_m_d;
            write_reg_m_q  <= write_reg_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            zero_m_q       <= zero_m_d;
            branch_m_q     <= branch_m_d;
        end
    end

    assign ALUOutM    = alu_out_m_q;
    assign WriteDataM = write_data_m_q;
    assign WriteRegM  = write_reg_m_q;
    assign RegWriteM  = reg_write_m_q;
    assign MemtoRegM  = mem_to_reg_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign PCSrcM     = branch_m_q & zero_m_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural alu beside it.
// Latency: expected EX/MEM contents are queued when an op sits in E and popped one clock later.
// Backpressure: StallE/FlushE exercised directly; the scoreboard queue never blocks.
module tb_alu_issue_stage;

    localparam int W = 32;
    localparam int R = 5;

    logic          clk;
    logic          reset;
    logic          StallE, FlushE;
    logic [W-1:0]  RD1D, RD2D, ImmExtD;
    logic [R-1:0]  RsD, RtD, RdD;
    logic [2:0]    ALUControlD;
    logic          ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, BranchD;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [W-1:0]  ResultW;
    logic [W-1:0]  SrcA, SrcB;
    logic [2:0]    ALUControl;
    logic [W-1:0]  ALUResult;
    logic          Zero;
    logic [R-1:0]  RsE, RtE, WriteRegE;
    logic          RegWriteE, MemtoRegE;
    logic [W-1:0]  ALUOutM, WriteDataM;
    logic [R-1:0]  WriteRegM;
    logic          RegWriteM, MemtoRegM, MemWriteM, PCSrcM;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] alu_out;
        logic [W-1:0] wdata;
        logic [R-1:0] wreg;
        logic         rw;
        logic         m2r;
        logic         mw;
        logic         pcsrc;
    } m_exp_t;

    m_exp_t sb[$];

    alu_issue_stage #(.WIDTH(W), .REGW(R)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .RsD         (RsD),
        .RtD         (RtD),
        .RdD         (RdD),
        .ALUControlD (ALUControlD),
        .ALUSrcD     (ALUSrcD),
        .RegDstD     (RegDstD),
        .RegWriteD   (RegWriteD),
        .MemtoRegD   (MemtoRegD),
        .MemWriteD   (MemWriteD),
        .BranchD     (BranchD),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .ALUControl  (ALUControl),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .RsE         (RsE),
        .RtE         (RtE),
        .WriteRegE   (WriteRegE),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .WriteRegM   (WriteRegM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .PCSrcM      (PCSrcM)
    );

    // Behavioural alu standing in for the real one.
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            3'b000: ALUResult = SrcA + SrcB;
            3'b001: ALUResult = SrcA - SrcB;
            3'b010: ALUResult = SrcA & SrcB;
            3'b011: ALUResult = SrcA | SrcB;
            3'b101: ALUResult = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            3'b111: ALUResult = SrcB << SrcA[4:0];
            default: ALUResult = '0;
        endcase
        Zero = (ALUResult == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                         input logic [W-1:0] imm, input logic [R-1:0] rs,
                         input logic [R-1:0] rt, input logic [R-1:0] rd,
                         input logic [2:0] ctl, input logic alusrc,
                         input logic regdst, input logic regwrite,
                         input logic memtoreg, input logic memwrite,
                         input logic branch);
        RD1D = rd1; RD2D = rd2; ImmExtD = imm;
        RsD = rs; RtD = rt; RdD = rd;
        ALUControlD = ctl; ALUSrcD = alusrc; RegDstD = regdst;
        RegWriteD = regwrite; MemtoRegD = memtoreg; MemWriteD = memwrite;
        BranchD = branch;
    endtask

    task automatic set_rand_d();
        set_d($urandom, $urandom, $urandom, R'($urandom), R'($urandom), R'($urandom),
              3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic push_m(input logic [W-1:0] alu_out, input logic [W-1:0] wdata,
                          input logic [R-1:0] wreg, input logic rw, input logic m2r,
                          input logic mw, input logic pcsrc);
        m_exp_t e;
        e.alu_out = alu_out; e.wdata = wdata; e.wreg = wreg;
        e.rw = rw; e.m2r = m2r; e.mw = mw; e.pcsrc = pcsrc;
        sb.push_back(e);
    endtask

    task automatic check_m(input string tag);
        m_exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ALUOutM"},    ALUOutM,           e.alu_out);
            chk({tag, "_WriteDataM"}, WriteDataM,        e.wdata);
            chk({tag, "_WriteRegM"},  32'(WriteRegM),    32'(e.wreg));
            chk({tag, "_RegWriteM"},  32'(RegWriteM),    32'(e.rw));
            chk({tag, "_MemtoRegM"},  32'(MemtoRegM),    32'(e.m2r));
            chk({tag, "_MemWriteM"},  32'(MemWriteM),    32'(e.mw));
            chk({tag, "_PCSrcM"},     32'(PCSrcM),       32'(e.pcsrc));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_SrcA"},       SrcA,              32'h0);
        chk({tag, "_SrcB"},       SrcB,              32'h0);
        chk({tag, "_ALUControl"}, 32'(ALUControl),   32'h0);
        chk({tag, "_RsE"},        32'(RsE),          32'h0);
        chk({tag, "_RtE"},        32'(RtE),          32'h0);
        chk({tag, "_WriteRegE"},  32'(WriteRegE),    32'h0);
        chk({tag, "_RegWriteE"},  32'(RegWriteE),    32'h0);
        chk({tag, "_MemtoRegE"},  32'(MemtoRegE),    32'h0);
        chk({tag, "_ALUOutM"},    ALUOutM,           32'h0);
        chk({tag, "_WriteDataM"}, WriteDataM,        32'h0);
        chk({tag, "_WriteRegM"},  32'(WriteRegM),    32'h0);
        chk({tag, "_RegWriteM"},  32'(RegWriteM),    32'h0);
        chk({tag, "_MemtoRegM"},  32'(MemtoRegM),    32'h0);
        chk({tag, "_MemWriteM"},  32'(MemWriteM),    32'h0);
        chk({tag, "_PCSrcM"},     32'(PCSrcM),       32'h0);
    endtask

    initial begin
        // 1. Reset with random decode inputs.
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = $urandom;
        set_rand_d();
        #12;
        check_zero("rst");
        reset = 1'b0;
        #1;
        check_zero("rst_rel");

        // 2. I1: add 1 + 0x10.
        set_d(32'h1, 32'h10, 32'h0, 5'd1, 5'd2, 5'd9, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("i1_SrcA", SrcA, 32'h1);
        chk("i1_SrcB", SrcB, 32'h10);
        chk("i1_ALUControl", 32'(ALUControl), 32'h0);
        chk("i1_RsE", 32'(RsE), 32'd1);
        chk("i1_WriteRegE", 32'(WriteRegE), 32'd2);
        chk("i1_RegWriteE", 32'(RegWriteE), 32'd1);
        push_m(32'h11, 32'h10, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // I2: add 2 + 3 = 5, to be forwarded from M into I3.
        set_d(32'h2, 32'h3, 32'h0, 5'd3, 5'd4, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_m("i1");
        push_m(32'h5, 32'h3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3. I3: sub with SrcA forwarded from ALUOutM, branch taken on zero.
        set_d(32'h99, 32'h5, 32'h0, 5'd4, 5'd5, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_m("i2");
        ForwardAE = 2'b10;
        #1;
        chk("i3_SrcA_fwd_mem", SrcA, 32'h5);
        chk("i3_SrcB", SrcB, 32'h5);
        chk("i3_ALUControl", 32'(ALUControl), 32'h1);
        push_m(32'h0, 32'h5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);

        // 4. I4: immediate operand, store data forwarded from ResultW.
        set_d(32'h7, 32'h33, 32'h4, 5'd6, 5'd6, 5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_m("i3");
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'hA5;
        #1;
        chk("i4_SrcA", SrcA, 32'h7);
        chk("i4_SrcB_imm", SrcB, 32'h4);
        push_m(32'hB, 32'hA5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);

        // 5. I5 then stall two cycles with new D values, then stall+flush.
        set_d(32'h100, 32'h200, 32'h0, 5'd7, 5'd8, 5'd0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_m("i4");
        ForwardBE = 2'b11;  // behaves as the register-file path
        #1;
        chk("i5_SrcA", SrcA, 32'h100);
        chk("i5_SrcB_fwd11", SrcB, 32'h200);
        push_m(32'h300, 32'h200, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        StallE = 1'b1;
        for (int s = 0; s < 2; s++) begin
            set_d(32'hDEAD + W'(s), 32'hBEEF, 32'h1, 5'd9, 5'd10, 5'd11, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            tick();
            check_m("stall");
            chk("stall_SrcA", SrcA, 32'h100);
            chk("stall_SrcB", SrcB, 32'h200);
            chk("stall_ALUControl", 32'(ALUControl), 32'h3);
            push_m(32'h300, 32'h200, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        FlushE = 1'b1;
        tick();
        check_m("pre_flush");
        chk("flush_ALUControl", 32'(ALUControl), 32'h0);
        chk("flush_SrcA", SrcA, 32'h0);
        chk("flush_SrcB", SrcB, 32'h0);
        chk("flush_RegWriteE", 32'(RegWriteE), 32'h0);
        chk("flush_WriteRegE", 32'(WriteRegE), 32'h0);
        push_m(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        StallE = 1'b0; FlushE = 1'b0; ForwardBE = 2'b00;

        // 6. I6: SLT -1 < 1, RegDst selects Rd.
        set_d(32'hFFFF_FFFF, 32'h1, 32'h0, 5'd1, 5'd3, 5'd7, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_m("bubble");
        chk("i6_WriteRegE", 32'(WriteRegE), 32'd7);
        chk("i6_ALUControl", 32'(ALUControl), 32'h5);
        push_m(32'h1, 32'h1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // I7: AND with load-style MemtoReg.
        set_d(32'hF0F0, 32'hFF00, 32'h0, 5'd2, 5'd10, 5'd12, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_m("i6");
        chk("i7_MemtoRegE", 32'(MemtoRegE), 32'h1);
        chk("i7_WriteRegE", 32'(WriteRegE), 32'd10);
        push_m(32'hF000, 32'hFF00, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_m("i7");

        // Reset asserted mid-stall, away from any clock edge.
        StallE = 1'b1;
        set_rand_d();
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("rst_mid_rel");
        tick();
        chk("post_rst_SrcA", SrcA, 32'h0);
        chk("post_rst_RegWriteE", 32'(RegWriteE), 32'h0);
        chk("post_rst_RegWriteM", 32'(RegWriteM), 32'h0);
        chk("post_rst_PCSrcM", 32'(PCSrcM), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
